// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the rv32i MEM-stage load/store unit: control word, FSM state,
// funct3 encodings and base byte-enable masks.
package mem_stage_lsu_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       data_read;
        logic       data_write;
    } control_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-cache request/response handshake between the MEM-stage LSU and the cache.
interface mem_stage_lsu_if;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;

    modport master (
        output data_read, data_write, data_mbe, data_addr, data_wdata,
        input  data_resp, data_rdata
    );

    modport slave (
        input  data_read, data_write, data_mbe, data_addr, data_wdata,
        output data_resp, data_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data on the way out,
// lane selection and extension of the returned word on the way back.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        mbe   = '0;
        wdata = '0;
        case (funct3[1:0])
            2'b00: begin
                mbe   = MASK_B << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                mbe   = MASK_H << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                mbe   = MASK_W;
                wdata = store_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_result = '0;
        case (funct3)
            F3_B:    load_result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_result = {24'd0, lane_b};
            F3_H:    load_result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_result = {16'd0, lane_h};
            F3_W:    load_result = rdata;
            default: load_result = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: captures the access, holds the cache request until data_resp, then
// presents the extended load result. LSU_MISALIGN_TRAP_EN adds misalign_o and skips the cache.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  control_word_t   ctrl,
    input  logic [31:0]     addr,
    input  logic [31:0]     store_data,
    input  logic            advance,
    mem_stage_lsu_if.master dmem,
    output logic [31:0]     load_result,
    output logic            stall_o,
    output logic [3:0]      mon_rmask,
    output logic [3:0]      mon_wmask,
    output logic [31:0]     mon_rdata,
    output logic [31:0]     mon_wdata,
    output logic            timeout_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);
    localparam int WD_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    lsu_state_t      state;
    logic            rd_q, wr_q;
    logic [3:0]      mbe_q;
    logic [31:0]     addr_q, wdata_q;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic [WD_W-1:0] wd_cnt;

    logic            mem_op;
    logic [2:0]      f3_sel;
    logic [1:0]      lo_sel;
    logic [3:0]      mbe_c;
    logic [31:0]     wdata_c, ld_c;
    logic            misaligned;

    assign mem_op  = in_valid & (ctrl.data_read | ctrl.data_write);
    assign stall_o = mem_op & (state != DONE);

    // Live instruction fields drive the aligner in IDLE; captured ones afterwards.
    assign f3_sel = (state == IDLE) ? ctrl.funct3 : f3_q;
    assign lo_sel = (state == IDLE) ? addr[1:0]   : lo_q;

    lsu_align u_align (
        .funct3     (f3_sel),
        .addr_lo    (lo_sel),
        .store_data (store_data),
        .rdata      (dmem.data_rdata),
        .mbe        (mbe_c),
        .wdata      (wdata_c),
        .load_result(ld_c)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign misalign_o = mis_q;
    assign misaligned = ((ctrl.data_read && ctrl.funct3 == F3_W) && (addr[1:0] != 2'b00))
                      || (((ctrl.data_read && (ctrl.funct3 == F3_H || ctrl.funct3 == F3_HU))
                      || (ctrl.data_write && ctrl.funct3 == F3_H)) && addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign dmem.data_read  = rd_q;
    assign dmem.data_write = wr_q;
    assign dmem.data_mbe   = mbe_q;
    assign dmem.data_addr  = addr_q;
    assign dmem.data_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            mbe_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            wd_cnt      <= '0;
            load_result <= '0;
            mon_rmask   <= '0;
            mon_wmask   <= '0;
            mon_rdata   <= '0;
            mon_wdata   <= '0;
            timeout_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    f3_q      <= ctrl.funct3;
                    lo_q      <= addr[1:0];
                    addr_q    <= {addr[31:2], 2'b00};
                    mbe_q     <= mbe_c;
                    wdata_q   <= wdata_c;
                    mon_wdata <= wdata_c;
                    if (misaligned) begin
                        state       <= DONE;
                        load_result <= '0;
                        mon_rmask   <= '0;
                        mon_wmask   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_q       <= 1'b1;
`endif
                    end else begin
                        state     <= BUSY;
                        rd_q      <= ctrl.data_read;
                        wr_q      <= ctrl.data_write & ~ctrl.data_read;
                        mon_rmask <= ctrl.data_read ? mbe_c : 4'b0000;
                        mon_wmask <= (ctrl.data_write & ~ctrl.data_read) ? mbe_c : 4'b0000;
                        wd_cnt    <= WD_W'(1);
                        if (MAX_WAIT == 1) timeout_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem.data_resp) begin
                        state       <= DONE;
                        rd_q        <= 1'b0;
                        wr_q        <= 1'b0;
                        mon_rdata   <= dmem.data_rdata;
                        load_result <= ld_c;
                    end else if (MAX_WAIT > 0 && wd_cnt != WD_W'(MAX_WAIT)) begin
                        // Count is the BUSY cycle number, so the flag shows in cycle MAX_WAIT.
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (wd_cnt + WD_W'(1) == WD_W'(MAX_WAIT)) timeout_err <= 1'b1;
                    end
                end
                DONE: if (advance) begin
                    state <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one task per scenario, inline checks, hand-computed values.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    control_word_t ctrl;
    logic [31:0]   addr, store_data;
    logic          advance;
    logic [31:0]   load_result, mon_rdata, mon_wdata;
    logic          stall_o, timeout_err;
    logic [3:0]    mon_rmask, mon_wmask;
`ifdef LSU_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif
    int tests_run = 0;
    int tests_failed = 0;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(.MAX_WAIT(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ctrl(ctrl), .addr(addr),
        .store_data(store_data), .advance(advance), .dmem(dmem),
        .load_result(load_result), .stall_o(stall_o), .mon_rmask(mon_rmask),
        .mon_wmask(mon_wmask), .mon_rdata(mon_rdata), .mon_wdata(mon_wdata),
        .timeout_err(timeout_err)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        in_valid   = 1'b1;
        ctrl       = '{opcode: rd ? 7'b0000011 : 7'b0100011, funct3: f3, data_read: rd, data_write: ~rd};
        addr       = a;
        store_data = d;
        #1;
    endtask

    task automatic finish_op;
        advance = 1'b1;
        step();
        advance  = 1'b0;
        in_valid = 1'b0;
    endtask

    // Load with response in the first BUSY cycle; leaves the DUT in DONE.
    task automatic load_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        issue(1'b1, f3, a, 32'h0);
        step();
        dmem.data_resp  = 1'b1;
        dmem.data_rdata = rd;
        step();
        dmem.data_resp = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        tests_run++;
        if ({dmem.data_read, dmem.data_write, dmem.data_mbe, dmem.data_addr, dmem.data_wdata} !== 70'd0) begin
            tests_failed++; $display("FAIL reset_req got=%0h exp=0", {dmem.data_read, dmem.data_write, dmem.data_mbe, dmem.data_addr, dmem.data_wdata});
        end
        tests_run++;
        if ({load_result, stall_o, mon_rmask, mon_wmask, mon_rdata, mon_wdata, timeout_err} !== 106'd0) begin
            tests_failed++; $display("FAIL reset_out got=%0h exp=0", {load_result, stall_o, mon_rmask, mon_wmask, mon_rdata, mon_wdata, timeout_err});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sw;
        issue(1'b0, F3_W, 32'h100, 32'hDEADBEEF);
        tests_run++;
        if (stall_o !== 1'b1 || dmem.data_write !== 1'b0) begin
            tests_failed++; $display("FAIL sw_c0 got stall=%b wr=%b exp stall=1 wr=0", stall_o, dmem.data_write);
        end
        step();
        tests_run++;
        if ({dmem.data_write, dmem.data_read, dmem.data_mbe, dmem.data_addr, dmem.data_wdata, stall_o} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1}) begin
            tests_failed++; $display("FAIL sw_req got wr=%b rd=%b mbe=%h addr=%h wd=%h stall=%b exp 1 0 f 100 deadbeef 1",
                dmem.data_write, dmem.data_read, dmem.data_mbe, dmem.data_addr, dmem.data_wdata, stall_o);
        end
        step();
        dmem.data_resp  = 1'b1;
        dmem.data_rdata = 32'h0;
        tests_run++;
        if (stall_o !== 1'b1 || dmem.data_write !== 1'b1) begin
            tests_failed++; $display("FAIL sw_c2 got stall=%b wr=%b exp 1 1", stall_o, dmem.data_write);
        end
        step();
        dmem.data_resp = 1'b0;
        tests_run++;
        if ({stall_o, dmem.data_write, mon_wmask, mon_rmask, mon_wdata} !== {1'b0, 1'b0, 4'hF, 4'h0, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL sw_done got stall=%b wr=%b wmask=%h rmask=%h wdata=%h exp 0 0 f 0 deadbeef",
                stall_o, dmem.data_write, mon_wmask, mon_rmask, mon_wdata);
        end
        finish_op();
    endtask

    task automatic test_lb;
        issue(1'b1, F3_B, 32'h203, 32'h0);
        step();
        tests_run++;
        if ({dmem.data_read, dmem.data_mbe, dmem.data_addr} !== {1'b1, 4'b1000, 32'h200}) begin
            tests_failed++; $display("FAIL lb_req got rd=%b mbe=%b addr=%h exp 1 1000 200", dmem.data_read, dmem.data_mbe, dmem.data_addr);
        end
        dmem.data_resp  = 1'b1;
        dmem.data_rdata = 32'h80FF1234;
        step();
        dmem.data_resp = 1'b0;
        tests_run++;
        if ({load_result, mon_rmask, mon_wmask, mon_rdata, stall_o, dmem.data_read} !== {32'hFFFFFF80, 4'b1000, 4'h0, 32'h80FF1234, 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL lb_done got lr=%h rmask=%b wmask=%b rdata=%h stall=%b rd=%b exp ffffff80 1000 0 80ff1234 0 0",
                load_result, mon_rmask, mon_wmask, mon_rdata, stall_o, dmem.data_read);
        end
        finish_op();
        load_fast(F3_BU, 32'h203, 32'h80FF1234);
        tests_run++;
        if (load_result !== 32'h00000080) begin
            tests_failed++; $display("FAIL lbu got=%h exp=00000080", load_result);
        end
        finish_op();
    endtask

    task automatic test_sh;
        issue(1'b0, F3_H, 32'h302, 32'h0000ABCD);
        step();
        tests_run++;
        if ({dmem.data_write, dmem.data_mbe, dmem.data_wdata, dmem.data_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h300}) begin
            tests_failed++; $display("FAIL sh_req got wr=%b mbe=%b wd=%h addr=%h exp 1 1100 abcdabcd 300",
                dmem.data_write, dmem.data_mbe, dmem.data_wdata, dmem.data_addr);
        end
        dmem.data_resp = 1'b1;
        step();
        dmem.data_resp = 1'b0;
        finish_op();
        load_fast(F3_HU, 32'h302, 32'hABCD0000);
        tests_run++;
        if (load_result !== 32'h0000ABCD) begin
            tests_failed++; $display("FAIL lhu got=%h exp=0000abcd", load_result);
        end
        finish_op();
        issue(1'b0, F3_B, 32'h501, 32'h123456A5);
        step();
        tests_run++;
        if ({dmem.data_mbe, dmem.data_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin
            tests_failed++; $display("FAIL sb_req got mbe=%b wd=%h exp 0010 a5a5a5a5", dmem.data_mbe, dmem.data_wdata);
        end
        dmem.data_resp = 1'b1;
        step();
        dmem.data_resp = 1'b0;
        finish_op();
    endtask

    task automatic test_extend;
        load_fast(F3_H, 32'h300, 32'h12348001);
        tests_run++;
        if (load_result !== 32'hFFFF8001) begin
            tests_failed++; $display("FAIL lh got=%h exp=ffff8001", load_result);
        end
        finish_op();
        load_fast(F3_B, 32'h301, 32'h00007F00);
        tests_run++;
        if (load_result !== 32'h0000007F) begin
            tests_failed++; $display("FAIL lb_pos got=%h exp=0000007f", load_result);
        end
        finish_op();
        load_fast(3'b011, 32'h300, 32'hCAFEF00D);
        tests_run++;
        if (load_result !== 32'h0 || mon_rdata !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL undef_f3 got lr=%h rdata=%h exp 0 cafef00d", load_result, mon_rdata);
        end
        finish_op();
    endtask

    task automatic test_done_hold;
        load_fast(F3_W, 32'h400, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                dmem.data_resp  = 1'b1;
                dmem.data_rdata = 32'h99999999;
            end
            step();
            dmem.data_resp = 1'b0;
            tests_run++;
            if ({dmem.data_read, load_result, mon_rdata, stall_o} !== {1'b0, 32'h11223344, 32'h11223344, 1'b0}) begin
                tests_failed++; $display("FAIL done_hold[%0d] got rd=%b lr=%h rdata=%h stall=%b exp 0 11223344 11223344 0",
                    i, dmem.data_read, load_result, mon_rdata, stall_o);
            end
        end
        advance = 1'b1;
        step();
        advance = 1'b0;
        tests_run++;
        if (stall_o !== 1'b1 || dmem.data_read !== 1'b0) begin
            tests_failed++; $display("FAIL done_to_idle got stall=%b rd=%b exp 1 0", stall_o, dmem.data_read);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_timeout;
        issue(1'b1, F3_W, 32'h600, 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            tests_run++;
            if (timeout_err !== (k >= 5) || dmem.data_read !== 1'b1) begin
                tests_failed++; $display("FAIL timeout_busy%0d got err=%b rd=%b exp %b 1", k, timeout_err, dmem.data_read, k >= 5);
            end
        end
        dmem.data_resp  = 1'b1;
        dmem.data_rdata = 32'h5;
        step();
        dmem.data_resp = 1'b0;
        finish_op();
        tests_run++;
        if (timeout_err !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
    endtask

    task automatic test_reset_busy;
        issue(1'b1, F3_W, 32'h700, 32'h0);
        step();
        tests_run++;
        if (dmem.data_read !== 1'b1) begin
            tests_failed++; $display("FAIL rstbusy_req got=%b exp=1", dmem.data_read);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        tests_run++;
        if ({dmem.data_read, dmem.data_mbe, dmem.data_addr, load_result, mon_rmask, mon_rdata, stall_o, timeout_err} !== 106'd0) begin
            tests_failed++; $display("FAIL rstbusy_out got rd=%b mbe=%h addr=%h lr=%h rmask=%h rdata=%h stall=%b err=%b exp all 0",
                dmem.data_read, dmem.data_mbe, dmem.data_addr, load_result, mon_rmask, mon_rdata, stall_o, timeout_err);
        end
        dmem.data_resp  = 1'b1;
        dmem.data_rdata = 32'hBAADF00D;
        step();
        dmem.data_resp = 1'b0;
        step();
        tests_run++;
        if ({load_result, mon_rdata, dmem.data_read, stall_o} !== 66'd0) begin
            tests_failed++; $display("FAIL late_resp got lr=%h rdata=%h rd=%b stall=%b exp 0", load_result, mon_rdata, dmem.data_read, stall_o);
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign;
        issue(1'b1, F3_W, 32'h101, 32'h0);
        step();
        tests_run++;
        if ({misalign_o, dmem.data_read, stall_o, load_result, mon_rmask} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
            tests_failed++; $display("FAIL misalign got mis=%b rd=%b stall=%b lr=%h rmask=%h exp 1 0 0 0 0",
                misalign_o, dmem.data_read, stall_o, load_result, mon_rmask);
        end
        finish_op();
        tests_run++;
        if (misalign_o !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_clr got=%b exp=0", misalign_o);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; advance = 1'b0;
        ctrl = '0; addr = '0; store_data = '0;
        dmem.data_resp = 1'b0; dmem.data_rdata = '0;
        test_reset();
        test_sw();
        test_lb();
        test_sh();
        test_extend();
        test_done_hold();
        test_timeout();
        test_reset_busy();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the rv32i pipeline, directly downstream of the EX/MEM register.
- Consumes control_word_t, ALU address and rs2 data; drives the data-cache handshake; stalls the pipeline until the response arrives.
- Produces an aligned, extended load result for the MEM/WB register and the mem_* fields of monitor_signals.

Parameters:
- MAX_WAIT, 0, cycles in BUSY before timeout_err sets; 0 disables the watchdog counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM register holds a live instruction
- ctrl  in  control_word_t  control word; uses opcode, funct3, data_read, data_write
- addr  in  32  byte address (ALU result)
- store_data  in  32  rs2 value, unshifted
- advance  in  1  global pipeline advance this cycle (no stall anywhere)
- data_read  out  1  cache read request
- data_write  out  1  cache write request
- data_mbe  out  4  byte enables
- data_addr  out  32  word-aligned address {addr[31:2],2'b00}
- data_wdata  out  32  lane-replicated store data
- data_resp  in  1  cache response, 1-cycle pulse
- data_rdata  in  32  read data, valid with data_resp
- load_result  out  32  extended load value, valid in DONE
- stall_o  out  1  MEM-stage stall request
- mon_rmask  out  4  rvfi read mask
- mon_wmask  out  4  rvfi write mask
- mon_rdata  out  32  raw cache word captured
- mon_wdata  out  32  = data_wdata as captured
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Captured address, data and masks cleared.
  - timeout_err cleared.
- mem_op = in_valid & (ctrl.data_read | ctrl.data_write).
- stall_o = mem_op & (state != DONE). This is combinational, and low for non-memory instructions.
- FSM states and transitions:
  - IDLE: on mem_op, capture data_addr, mbe, wdata, funct3 and read/write, then go to BUSY. Cache request lines are low in IDLE.
  - BUSY: data_read or data_write is held high, with all request fields stable, until data_resp. On data_resp, capture data_rdata into mon_rdata, compute load_result, drop the request in the same cycle (outputs registered low next edge), then go to DONE.
  - DONE: stall_o low and load_result/mon_* stable. On advance, go to IDLE. Without advance, stay in DONE with no re-request.
- Minimum latency, resp in the first BUSY cycle:
  - Request is visible 1 cycle after the instruction arrives.
  - DONE follows on the next cycle.
  - The instruction leaves MEM 3 cycles after arrival.
- Masks:
  - sb: 4'b0001<<addr[1:0]
  - sh: 4'b0011<<{addr[1],1'b0}
  - sw: 4'b1111
  - mon_rmask holds the mask on loads and is 0 on stores; mon_wmask is the converse.
- Store data:
  - sb replicates byte[7:0] to 4 lanes.
  - sh replicates half[15:0] to 2 lanes.
  - sw passes store_data through.
- Loads select the lane by addr[1:0]:
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
  - lw passes the word through.
  - Undefined funct3 yields 0.
- Boundary cases:
  - data_resp arriving in IDLE or DONE is ignored.
  - rst in BUSY returns to IDLE and drops the request next edge; the cache is required to tolerate the abandoned request.
  - An instruction change while in BUSY cannot occur because stall_o holds EX/MEM.
- Watchdog (MAX_WAIT>0):
  - The counter resets on entering BUSY and increments each BUSY cycle.
  - When count==MAX_WAIT, timeout_err sets and stays set until rst.
  - The FSM keeps waiting.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - lw with addr[1:0]!=0, or lh/lhu/sh with addr[0]=1, is misaligned.
  - A misaligned access skips BUSY and goes IDLE->DONE directly with no cache request.
  - load_result=0, mon masks=0.
  - Extra output port misalign_o=1 while in that DONE.
- Undefined:
  - No misalign_o port.
  - Low address bits beyond the lane select are ignored; the access is performed as if aligned down (sh at addr[0]=1 uses lanes per addr[1]).

Decomposition:
- rv32i_types gains lsu_state_t (IDLE, BUSY, DONE) and constants for the byte, half and word base masks.
- Sub-module lsu_align is combinational:
  - Inputs: funct3, addr[1:0], store_data, raw rdata.
  - Outputs: mbe, wdata, load_result.
- mem_stage_lsu owns the FSM, capture registers, watchdog and monitor registers.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, resp 2 cycles after request:
  - data_write=1, mbe=1111, data_addr=0x100.
  - stall_o high 3 cycles.
  - mon_wmask=1111.
- lb addr=0x203, rdata=0x80FF1234, resp immediate:
  - mbe=1000, load_result=0xFFFFFF80.
  - Same access as lbu gives load_result=0x00000080.
- sh addr=0x302, data=0x0000ABCD:
  - mbe=1100, data_wdata=0xABCDABCD.
  - lhu of the same address, rdata=0xABCD0000, gives 0x0000ABCD.
- DONE with advance=0 for 4 cycles:
  - No second request.
  - load_result stable.
  - stall_o=0.
  - IDLE after advance.
- rst asserted in BUSY:
  - data_read=0 next cycle.
  - All outputs 0.
  - Late data_resp ignored.
- MAX_WAIT=5, no resp: timeout_err=1 on the 5th BUSY cycle and stays set. With LSU_MISALIGN_TRAP_EN, lw addr=0x101 gives misalign_o=1 and no data_read.
